// File: rtl/game_tick_sequencer_if.sv
// rtl/game_tick_sequencer_if.sv - stage handshake and status bundle; pause signal exists only with TICK_PAUSE_EN
interface game_tick_sequencer_if #(
  parameter int NSTAGE = 3
);
  logic [NSTAGE-1:0] stage_start;
  logic [NSTAGE-1:0] stage_done;
  logic              tick;
  logic              busy;
  logic [15:0]       frame_cnt;
  logic [7:0]        overrun_cnt;
  logic              timeout_err;
`ifdef TICK_PAUSE_EN
  logic              pause;

  modport master (
    output stage_start, tick, busy, frame_cnt, overrun_cnt, timeout_err,
    input  stage_done, pause
  );

  modport slave (
    input  stage_start, tick, busy, frame_cnt, overrun_cnt, timeout_err,
    output stage_done, pause
  );
`else
  modport master (
    output stage_start, tick, busy, frame_cnt, overrun_cnt, timeout_err,
    input  stage_done
  );

  modport slave (
    input  stage_start, tick, busy, frame_cnt, overrun_cnt, timeout_err,
    output stage_done
  );
`endif
endinterface

// File: rtl/game_tick_sequencer.sv
// rtl/game_tick_sequencer.sv - game tick prescaler plus start/done stage sequencer; TICK_PAUSE_EN adds prescaler pause
module game_tick_sequencer #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 10,
  parameter int NSTAGE  = 3,
  parameter int TIMEOUT = 4095
) (
  input logic                   clk12Mhz,
  input logic                   rst,
  game_tick_sequencer_if.master bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int WW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  localparam logic [CW-1:0]     CNT_LAST = CW'(DIV - 1);
  localparam logic [WW-1:0]     WAIT_MAX = WW'(TIMEOUT);
  localparam logic [IW-1:0]     IDX_LAST = IW'(NSTAGE - 1);
  localparam logic [NSTAGE-1:0] ONE      = NSTAGE'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [IW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          hold;
  logic          tick_r;
  logic          stage_hit;
  logic          stage_expired;

  // Next prescaler value; a held count freezes both the count and the tick.
  always_comb begin
    hold = 1'b0;
`ifdef TICK_PAUSE_EN
    hold = bus.pause;
`endif
    cnt_nxt = cnt;
    if (!hold) begin
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Prescaler with registered tick: tick is high in the cycle whose count is DIV-1.
  always_ff @(posedge clk12Mhz) begin
    if (rst) begin
      cnt    <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tick_r <= !hold && (cnt_nxt == CNT_LAST);
    end
  end

  assign stage_hit     = bus.stage_done[idx];
  assign stage_expired = (wcnt == WAIT_MAX);

  // Frame sequencer: issue each stage in turn, wait for its done or a timeout, then count the frame.
  always_ff @(posedge clk12Mhz) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      wcnt            <= '0;
      bus.stage_start <= '0;
      bus.frame_cnt   <= '0;
      bus.overrun_cnt <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.stage_start <= '0;
      // A tick that finds a frame still running is dropped and counted.
      if (tick_r && (state != IDLE) && (bus.overrun_cnt != 8'hFF)) begin
        bus.overrun_cnt <= bus.overrun_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          if (tick_r) begin
            idx             <= '0;
            bus.stage_start <= ONE;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (stage_hit || stage_expired) begin
            // A done arriving on the last allowed cycle still counts as an answer.
            if (!stage_hit) begin
              bus.timeout_err <= 1'b1;
            end
            if (idx == IDX_LAST) begin
              bus.frame_cnt <= bus.frame_cnt + 16'd1;
              state         <= DONE;
            end else begin
              idx             <= idx + 1'b1;
              bus.stage_start <= ONE << (idx + 1'b1);
              state           <= ISSUE;
            end
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.tick = tick_r;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_game_tick_sequencer.sv
// tb/tb_game_tick_sequencer.sv - self-checking bench for game_tick_sequencer (DIV=10, NSTAGE=3, TIMEOUT=8)
module tb_game_tick_sequencer;
  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NSTAGE  = 3;
  localparam int TIMEOUT = 8;
  localparam int MAXC    = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_tick_sequencer_if #(.NSTAGE(NSTAGE)) bus ();

  game_tick_sequencer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .NSTAGE (NSTAGE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk12Mhz(clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus per cycle
  logic [2:0] done_vec [MAXC];
  logic       pause_vec[MAXC];
  // expected per cycle
  logic       e_tick [MAXC];
  logic [2:0] e_start[MAXC];
  logic       e_busy [MAXC];
  logic [15:0] e_frame[MAXC];
  logic [7:0] e_ovr  [MAXC];
  logic       e_err  [MAXC];
  // recorded per cycle
  logic       r_tick [MAXC];
  logic [2:0] r_start[MAXC];
  logic       r_busy [MAXC];
  logic [15:0] r_frame[MAXC];
  logic [7:0] r_ovr  [MAXC];
  logic       r_err  [MAXC];
  // model scratch
  int wst[MAXC];
  int fev[MAXC];
  int oev[MAXC];
  // responder delay per frame and stage; a delay above TIMEOUT means no answer
  int dly[64][NSTAGE];

  typedef struct {
    logic [2:0]  done;
    logic [2:0]  start;
    logic        tick;
    logic        busy;
    logic [15:0] frame;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      done_vec[c]  = '0;
      pause_vec[c] = 1'b0;
    end
  endtask

  task automatic set_dly(input int v);
    for (int f = 0; f < 64; f++)
      for (int i = 0; i < NSTAGE; i++) dly[f][i] = v;
  endtask

  task automatic rand_dly();
    int r;
    for (int f = 0; f < 64; f++)
      for (int i = 0; i < NSTAGE; i++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      dly[f][i] = $urandom_range(0, 2);
        else if (r < 85) dly[f][i] = $urandom_range(3, TIMEOUT);
        else             dly[f][i] = TIMEOUT + 1;
      end
  endtask

  // Frame-level schedule: ticks every DIV cycles; a frame occupies one issue cycle plus
  // min(delay,TIMEOUT)+1 wait cycles per stage, then one closing cycle.
  task automatic build_model(input int n, input bit spur);
    int free_at, f, t, s, w, d, err_at, fr, ov;
    logic [2:0] r;
    for (int c = 0; c < MAXC; c++) begin
      e_tick[c] = 1'b0; e_start[c] = '0; e_busy[c] = 1'b0;
      wst[c] = -1; fev[c] = 0; oev[c] = 0; done_vec[c] = '0;
    end
    free_at = 0; f = 0; err_at = MAXC;
    for (int T = DIV - 1; T < n; T += DIV) begin
      e_tick[T] = 1'b1;
      if (T >= free_at) begin
        t = T + 1;
        for (int i = 0; i < NSTAGE; i++) begin
          s = t;
          d = dly[f][i];
          e_start[s] = 3'(1 << i);
          w = s + 1 + ((d > TIMEOUT) ? TIMEOUT : d);
          for (int c = s; c <= w; c++) e_busy[c] = 1'b1;
          for (int c = s + 1; c <= w; c++) wst[c] = i;
          if (d <= TIMEOUT) done_vec[w][i] = 1'b1;
          else if (w + 1 < err_at) err_at = w + 1;
          t = w + 1;
        end
        e_busy[t] = 1'b1;
        fev[t]++;
        free_at = t + 1;
        f++;
      end else begin
        oev[T + 1]++;
      end
    end
    fr = 0; ov = 0;
    for (int c = 0; c < MAXC; c++) begin
      fr += fev[c];
      ov += oev[c];
      if (ov > 255) ov = 255;
      e_frame[c] = fr[15:0];
      e_ovr[c]   = ov[7:0];
      e_err[c]   = (c >= err_at);
    end
    if (spur) begin
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = 3'($urandom_range(0, 7));
          if (wst[c] >= 0) r[wst[c]] = 1'b0;
          done_vec[c] = done_vec[c] | r;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.stage_done = '0;
`ifdef TICK_PAUSE_EN
    bus.pause = 1'b0;
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle 0 is the first cycle after the reset edge; inputs applied just after the edge, outputs read at negedge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      bus.stage_done = done_vec[c];
`ifdef TICK_PAUSE_EN
      bus.pause = pause_vec[c];
`endif
      @(negedge clk);
      r_tick[c]  = bus.tick;
      r_start[c] = bus.stage_start;
      r_busy[c]  = bus.busy;
      r_frame[c] = bus.frame_cnt;
      r_ovr[c]   = bus.overrun_cnt;
      r_err[c]   = bus.timeout_err;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_model(input int n);
    for (int c = 0; c < n; c++) begin
      chk("tick", c, 32'(r_tick[c]), 32'(e_tick[c]));
      chk("stage_start", c, 32'(r_start[c]), 32'(e_start[c]));
      chk("busy", c, 32'(r_busy[c]), 32'(e_busy[c]));
      chk("frame_cnt", c, 32'(r_frame[c]), 32'(e_frame[c]));
      chk("overrun_cnt", c, 32'(r_ovr[c]), 32'(e_ovr[c]));
      chk("timeout_err", c, 32'(r_err[c]), 32'(e_err[c]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_s;
    bus.stage_done = '0;
`ifdef TICK_PAUSE_EN
    bus.pause = 1'b0;
`endif

    // Directed first frame: ignored done in ISSUE and on a foreign bit, then staggered answers.
    for (int i = 0; i < 20; i++) tbl[i] = '{done: 3'b000, start: 3'b000, tick: 1'b0, busy: 1'b0, frame: 16'd0};
    tbl[9].tick  = 1'b1;
    tbl[10].done = 3'b001; tbl[10].start = 3'b001;
    tbl[11].done = 3'b100;
    tbl[12].done = 3'b001;
    tbl[13].start = 3'b010;
    tbl[14].done = 3'b010;
    tbl[15].start = 3'b100;
    tbl[16].done = 3'b100;
    for (int i = 10; i <= 17; i++) tbl[i].busy = 1'b1;
    for (int i = 17; i < 20; i++) tbl[i].frame = 16'd1;
    tbl[19].tick = 1'b1;

    clear_stim();
    for (int c = 0; c < 20; c++) done_vec[c] = tbl[c].done;
    do_reset();
    run(20);
    for (int c = 0; c < 20; c++) begin
      chk("tbl_tick", c, 32'(r_tick[c]), 32'(tbl[c].tick));
      chk("tbl_start", c, 32'(r_start[c]), 32'(tbl[c].start));
      chk("tbl_busy", c, 32'(r_busy[c]), 32'(tbl[c].busy));
      chk("tbl_frame", c, 32'(r_frame[c]), 32'(tbl[c].frame));
      chk("tbl_ovr", c, 32'(r_ovr[c]), 32'd0);
      chk("tbl_err", c, 32'(r_err[c]), 32'd0);
    end

    // Every stage answers the cycle after its start.
    clear_stim(); set_dly(0);
    build_model(40, 1'b0);
    do_reset(); run(40); check_model(40);
    chk("fast_start0", 10, 32'(r_start[10]), 32'd1);
    chk("fast_start1", 12, 32'(r_start[12]), 32'd2);
    chk("fast_start2", 14, 32'(r_start[14]), 32'd4);
    chk("fast_frame", 16, 32'(r_frame[16]), 32'd1);
    chk("fast_busy", 17, 32'(r_busy[17]), 32'd0);
    chk("fast_tick", 29, 32'(r_tick[29]), 32'd1);

    // Stage 1 never answers: timeout, stage 2 still runs, tick at 19 overruns.
    clear_stim(); set_dly(0); dly[0][1] = TIMEOUT + 1;
    build_model(60, 1'b0);
    do_reset(); run(60); check_model(60);
    chk("to_err_before", 21, 32'(r_err[21]), 32'd0);
    chk("to_err_set", 22, 32'(r_err[22]), 32'd1);
    chk("to_start2", 22, 32'(r_start[22]), 32'd4);
    chk("to_overrun", 20, 32'(r_ovr[20]), 32'd1);
    chk("to_frame", 24, 32'(r_frame[24]), 32'd1);
    chk("to_err_sticky", 59, 32'(r_err[59]), 32'd1);

    // Stage 0 answers on the last allowed wait cycle: done beats timeout; tick at 19 overruns.
    clear_stim(); set_dly(0); dly[0][0] = TIMEOUT;
    build_model(60, 1'b0);
    do_reset(); run(60); check_model(60);
    chk("late_overrun", 20, 32'(r_ovr[20]), 32'd1);
    chk("late_start1", 20, 32'(r_start[20]), 32'd2);
    chk("late_no_err", 59, 32'(r_err[59]), 32'd0);

    // Reset while waiting on stage 1 aborts the frame.
    clear_stim(); set_dly(0); dly[0][1] = 5;
    build_model(14, 1'b0);
    do_reset(); run(14); check_model(14);
    rst = 1'b1;
    bus.stage_done = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_stim(); set_dly(0);
    build_model(20, 1'b0);
    run(20); check_model(20);
    cnt_s = 0;
    for (int c = 0; c < 10; c++) if (r_start[c] != 3'b000) cnt_s++;
    chk("rst_no_start", 0, 32'(cnt_s), 32'd0);
    chk("rst_start0", 10, 32'(r_start[10]), 32'd1);
    chk("rst_frame", 0, 32'(r_frame[0]), 32'd0);

`ifdef TICK_PAUSE_EN
    // Pause at prescaler count 4 for 25 cycles; tick comes 5 cycles after release.
    clear_stim();
    for (int c = 4; c < 29; c++) pause_vec[c] = 1'b1;
    do_reset(); run(40);
    cnt_s = 0;
    for (int c = 0; c < 34; c++) if (r_tick[c]) cnt_s++;
    chk("pause_no_tick", 0, 32'(cnt_s), 32'd0);
    chk("pause_tick", 34, 32'(r_tick[34]), 32'd1);
`endif

    // Randomized answer delays with stray done pulses on non-waiting bits.
    for (int k = 0; k < 3; k++) begin
      clear_stim(); rand_dly();
      build_model(400, 1'b1);
      do_reset(); run(400); check_model(400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
